uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. It oversamples the `rx` line on every `tick` clock edge, locates the middle of each bit and assembles the byte. On a valid stop bit it presents the byte on `data` with a one-cycle `done` strobe. It sits between the board-level serial input pin and the byte-oriented host logic, and exposes its FSM state for debug.

## Interface
- `OVERSAMPLE`, default 16: `tick` cycles per bit period. Must be even and ≥ 4.
- `tick` input 1: clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line. Idle level is 1.
- `data` output 8: last correctly framed byte. Held until the next valid frame.
- `done` output 1: one-cycle pulse when `data` is updated.
- `state` output 3: current FSM state encoding, for debug.

One clock; reset is asynchronous and active-high.

## Operation
Bit counter `cnt` has width $clog2(OVERSAMPLE). Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.

FSM states and encodings:
- IDLE = 3'd0
  - `cnt` is held at 0.
  - `rx`=0 sampled → START.
- START = 3'd1
  - `cnt` increments every cycle.
  - At `cnt` = OVERSAMPLE/2−1 (mid start bit): if `rx`=0 → DATA, with `cnt`=0 and `idx`=0.
  - If `rx`=1 at that point → IDLE. This rejects glitches.
- DATA = 3'd2
  - At `cnt` = OVERSAMPLE−1: sample `rx` into `sh[idx]`, set `cnt`=0, increment `idx`.
  - After the sample taken at `idx`=7 → STOP.
- STOP = 3'd3
  - At `cnt` = OVERSAMPLE−1, sample `rx`.
  - 1 → DONE, and latch `data` ← `sh`.
  - 0 → ERROR (framing error). `data` is unchanged.
- DONE = 3'd4
  - `done`=1 for this single cycle.
  - Unconditionally → IDLE.
- ERROR = 3'd5
  - Wait until `rx`=1 is sampled, then → IDLE.
  - No `done` pulse.
- Encodings 6 and 7 are illegal and → IDLE on the next cycle.

Reset values:
- `state`=IDLE, `data`=8'h00, `done`=0.
- `cnt`=0, `idx`=0, `sh`=0.

Reset asserted mid-frame:
- The frame is discarded immediately.
- No `done` pulse.
- The receiver resynchronises on the next falling edge after reset is released.

Receiver behaviour:
- A line that stays low after a framing error does not retrigger reception until it returns high.
- The receiver is single-buffered. A new frame overwrites `data` only at its own valid stop bit.

## Timing
- Let cycle 0 be the first cycle `rx`=0 is sampled in IDLE.
- START check at cycle OVERSAMPLE/2 (8).
- Data bit k sampled at cycle OVERSAMPLE/2 + (k+1)·OVERSAMPLE. With the default OVERSAMPLE, bit 0 is at cycle 24 and bit 7 at cycle 136.
- Stop bit sampled at cycle OVERSAMPLE/2 + 9·OVERSAMPLE (152).
- `data` valid and `done` high at cycle 153, for exactly one cycle.
- IDLE again at cycle 154. Back-to-back frames with a one-bit stop are accepted.
- `state` is the registered FSM state; it changes on the same edge as the transition.

## Configuration
- `UART_RX_SYNC_EN`
  - Defined: `rx` passes through a two-flop synchronizer, reset to 1, before the FSM. All latencies above grow by 2 cycles.
  - Undefined: the FSM samples `rx` directly. The source must then be synchronous to `tick`.

## Test plan
- Reset → `data`=8'h00, `done`=0, `state`=0. Idle line (`rx`=1) for 100 cycles → `state` stays 0 and `done` never pulses.
- Frame 8'hAA (bits 0,1,0,1,0,1,0,1 LSB first, 16 cycles per bit, stop=1):
  - `state` steps 1→2→3→4→0.
  - `data`=8'hAA with a single `done` pulse 153 cycles after the start edge (155 with `UART_RX_SYNC_EN`).
- Glitch: `rx` low for 4 cycles, then high → `state` returns to 0 at the mid-start check, no `done`, `data` unchanged.
- Framing error: frame 8'h5A with stop bit 0 → `state`=5, no `done`, `data` keeps its previous value. `rx` high → `state`=0.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap → two `done` pulses, `data`=8'h00 then 8'hFF.
- Reset pulse asserted at data bit 4 of a frame → `state`=0 immediately, no `done`. A subsequent clean frame 8'h3C is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling; optional UART_RX_SYNC_EN input synchronizer
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       tick,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       done,
  output logic [2:0] state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            rx_s;

`ifdef UART_RX_SYNC_EN
  // Two-flop synchronizer, preset to the idle level so reset never looks like a start bit
  logic [1:0] sync_q;
  always_ff @(posedge tick or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = 3'd0;
          // A start bit that is gone by mid-bit was a glitch
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FULL_M1) begin
          sh_d[idx_q] = rx_s;
          cnt_d       = '0;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_DONE;
            data_d  = sh_q;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data  = data_q;
  assign done  = (state_q == S_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int OS = 16;

  logic       tick = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       done;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int start_cyc = 0;
  int d0;
  int nz;
  logic [2:0] st_log [5];
  logic [2:0] s_a, s_b;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .tick (tick),
    .reset(reset),
    .rx   (rx),
    .data (data),
    .done (done),
    .state(state)
  );

  always #5 tick = ~tick;

  always @(posedge tick) cyc++;

  always @(negedge tick) begin
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tick);
    #1;
  endtask

  // Drives ncyc cycles of an 8N1 frame; the first edge after rx falls is edge 0
  task automatic send(input logic [7:0] b, input logic stop, input int ncyc);
    start_cyc = cyc;
    for (int i = 0; i < ncyc; i++) begin
      int bi;
      bi = i / OS;
      if (bi == 0)      rx = 1'b0;
      else if (bi <= 8) rx = b[bi-1];
      else              rx = stop;
      step();
      if (i == LAT)       st_log[0] = state;
      if (i == LAT + 8)   st_log[1] = state;
      if (i == LAT + 136) st_log[2] = state;
      if (i == LAT + 152) st_log[3] = state;
      if (i == LAT + 153) st_log[4] = state;
    end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) step();
    check("reset_data", 32'(data), 32'h00);
    check("reset_done", 32'(done), 32'h0);
    check("reset_state", 32'(state), 32'h0);
    reset = 1'b0;

    nz = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (state !== 3'd0) nz++;
    end
    check("idle_state", 32'(nz), 32'd0);
    check("idle_done", 32'(done_cnt), 32'd0);

    d0 = done_cnt;
    send(8'hAA, 1'b1, 160);
    check("aa_st_start", 32'(st_log[0]), 32'd1);
    check("aa_st_data", 32'(st_log[1]), 32'd2);
    check("aa_st_stop", 32'(st_log[2]), 32'd3);
    check("aa_st_done", 32'(st_log[3]), 32'd4);
    check("aa_st_idle", 32'(st_log[4]), 32'd0);
    check("aa_data", 32'(data), 32'hAA);
    check("aa_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("aa_latency", 32'(last_done_cyc - start_cyc), 32'(153 + LAT));
    rx = 1'b1;
    repeat (20) step();

    d0 = done_cnt;
    s_a = 3'd7;
    s_b = 3'd7;
    for (int i = 0; i < 20; i++) begin
      rx = (i < 4) ? 1'b0 : 1'b1;
      step();
      if (i == LAT + 7) s_a = state;
      if (i == LAT + 8) s_b = state;
    end
    check("glitch_start", 32'(s_a), 32'd1);
    check("glitch_idle", 32'(s_b), 32'd0);
    check("glitch_done", 32'(done_cnt), 32'(d0));
    check("glitch_data", 32'(data), 32'hAA);

    d0 = done_cnt;
    send(8'h5A, 1'b0, 160);
    check("ferr_state", 32'(st_log[3]), 32'd5);
    repeat (30) step();
    check("ferr_hold", 32'(state), 32'd5);
    check("ferr_done", 32'(done_cnt), 32'(d0));
    check("ferr_data", 32'(data), 32'hAA);
    rx = 1'b1;
    repeat (4) step();
    check("ferr_recover", 32'(state), 32'd0);

    d0 = done_cnt;
    send(8'h00, 1'b1, 160);
    check("b2b_data0", 32'(data), 32'h00);
    check("b2b_cnt0", 32'(done_cnt), 32'(d0 + 1));
    send(8'hFF, 1'b1, 160);
    check("b2b_data1", 32'(data), 32'hFF);
    check("b2b_cnt1", 32'(done_cnt), 32'(d0 + 2));
    rx = 1'b1;
    repeat (20) step();

    d0 = done_cnt;
    send(8'hA5, 1'b1, OS * 5 + 8);
    check("rst_mid_data_state", 32'(state), 32'd2);
    reset = 1'b1;
    #2;
    check("rst_async_state", 32'(state), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    check("rst_async_data", 32'(data), 32'h00);
    rx = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();
    check("rst_no_done", 32'(done_cnt), 32'(d0));
    send(8'h3C, 1'b1, 160);
    check("rst_after_data", 32'(data), 32'h3C);
    check("rst_after_cnt", 32'(done_cnt), 32'(d0 + 1));
    rx = 1'b1;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
